// File: rtl/vga_scanout.sv
// vga_scanout: parametrised VGA timing generator and framebuffer scan-out.
//
// Walks the raster with free-running h/v counters, produces the frame RAM
// read address incrementally (no multiplier), and drives RGB/HS/VS from the
// returned RAM data.  The timing strobes are delayed so that they stay
// aligned with the pixel data.
//
// Ports:
//   clock        pixel clock, all logic on rising edge
//   reset        synchronous, active-high
//   ram_address  frame RAM read address (port B)
//   q            RAM read data {R,G,B}, R in MSBs
//   VGA_R/G/B    colour pins, zero outside active video
//   VGA_HS/VS    sync pins, asserted level = SYNC_POL
//   frame_start  one-clock pulse aligned with pixel (0,0) on the pins
//   vblank       high while v_count >= V_ACTIVE (counter-aligned)
module vga_scanout #(
    parameter int H_ACTIVE       = 640,
    parameter int H_FP           = 16,
    parameter int H_SYNC         = 96,
    parameter int H_BP           = 48,
    parameter int V_ACTIVE       = 480,
    parameter int V_FP           = 10,
    parameter int V_SYNC         = 2,
    parameter int V_BP           = 33,
    parameter int COLOR_BITS     = 3,
    parameter int PIX_SCALE_LOG2 = 2,
    parameter int RAM_LATENCY    = 2,
    parameter int SYNC_POL       = 0,
    parameter int ADDR_WIDTH     = 15
) (
    input  logic                    clock,
    input  logic                    reset,
    output logic [ADDR_WIDTH-1:0]   ram_address,
    input  logic [3*COLOR_BITS-1:0] q,
    output logic [COLOR_BITS-1:0]   VGA_R,
    output logic [COLOR_BITS-1:0]   VGA_G,
    output logic [COLOR_BITS-1:0]   VGA_B,
    output logic                    VGA_HS,
    output logic                    VGA_VS,
    output logic                    frame_start,
    output logic                    vblank
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int S       = PIX_SCALE_LOG2;
    localparam int W       = H_ACTIVE >> S;
    localparam int ROWS    = V_ACTIVE >> S;
    // Strobes are taken from the last stage one clock before the pin register.
    localparam int DLY     = RAM_LATENCY + 1;

    localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT        = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_ACT_LAST   = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] H_SYNC_FIRST = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [HW-1:0] H_MASK       = HW'((1 << S) - 1);
    localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT        = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_ACT_LAST   = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] V_SYNC_FIRST = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [VW-1:0] V_MASK       = VW'((1 << S) - 1);
    localparam logic [ADDR_WIDTH-1:0] W_A  = ADDR_WIDTH'(W);
    localparam logic SYNC_ON               = (SYNC_POL != 0);

    if ((H_ACTIVE % (1 << S)) != 0 || (V_ACTIVE % (1 << S)) != 0) begin : g_bad_scale
        $error("vga_scanout: active size not divisible by pixel scale");
    end
    if (longint'(W) * longint'(ROWS) > (64'd1 << ADDR_WIDTH)) begin : g_bad_addr
        $error("vga_scanout: framebuffer does not fit in ADDR_WIDTH");
    end

    logic [HW-1:0]         h_count;
    logic [VW-1:0]         v_count;
    logic [ADDR_WIDTH-1:0] line_base;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [ADDR_WIDTH-1:0] next_base;
    logic                  h_wrap, v_wrap, de, hs_now, vs_now, fs_now, line_end;
    logic [DLY-1:0]        de_pipe, hs_pipe, vs_pipe, fs_pipe;

    assign h_wrap   = (h_count == H_LAST);
    assign v_wrap   = (v_count == V_LAST);
    assign de       = (h_count < H_ACT) && (v_count < V_ACT);
    assign hs_now   = (h_count >= H_SYNC_FIRST) && (h_count <= H_SYNC_LAST);
    assign vs_now   = (v_count >= V_SYNC_FIRST) && (v_count <= V_SYNC_LAST);
    assign fs_now   = (h_count == '0) && (v_count == '0);
    assign line_end = (h_count == H_ACT_LAST) && (v_count < V_ACT);
    assign vblank   = (v_count >= V_ACT);

    // Address of the pixel the counters point at.  ram_address still holds
    // the previous pixel's address, so within a line we only step it once
    // per replicated group of 2^S pixels.
    always_comb begin
        next_addr = line_base;
        if (de) begin
            if (h_count == '0) begin
                next_addr = line_base;
            end else if ((h_count & H_MASK) == '0) begin
                next_addr = ram_address + ADDR_WIDTH'(1);
            end else begin
                next_addr = ram_address;
            end
        end
    end

    // Row base advances after the last replica of a stored row.  After the
    // final visible row it returns to 0 so the address never passes the end
    // of the framebuffer during vertical blanking.
    always_comb begin
        next_base = line_base;
        if (h_wrap && v_wrap) begin
            next_base = '0;
        end else if (line_end) begin
            if (v_count == V_ACT_LAST) begin
                next_base = '0;
            end else if ((v_count & V_MASK) == V_MASK) begin
                next_base = line_base + W_A;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            h_count     <= '0;
            v_count     <= '0;
            line_base   <= '0;
            ram_address <= '0;
        end else begin
            ram_address <= next_addr;
            line_base   <= next_base;
            if (h_wrap) begin
                h_count <= '0;
                v_count <= v_wrap ? '0 : v_count + VW'(1);
            end else begin
                h_count <= h_count + HW'(1);
            end
        end
    end

    // Strobe delay line; its last stage lines up with q for the same pixel.
    always_ff @(posedge clock) begin
        if (reset) begin
            de_pipe <= '0;
            hs_pipe <= '0;
            vs_pipe <= '0;
            fs_pipe <= '0;
        end else begin
            de_pipe[0] <= de;
            hs_pipe[0] <= hs_now;
            vs_pipe[0] <= vs_now;
            fs_pipe[0] <= fs_now;
            for (int i = 1; i < DLY; i++) begin
                de_pipe[i] <= de_pipe[i-1];
                hs_pipe[i] <= hs_pipe[i-1];
                vs_pipe[i] <= vs_pipe[i-1];
                fs_pipe[i] <= fs_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            VGA_HS      <= ~SYNC_ON;
            VGA_VS      <= ~SYNC_ON;
            frame_start <= 1'b0;
        end else begin
            VGA_R       <= de_pipe[DLY-1] ? q[3*COLOR_BITS-1:2*COLOR_BITS] : '0;
            VGA_G       <= de_pipe[DLY-1] ? q[2*COLOR_BITS-1:COLOR_BITS]   : '0;
            VGA_B       <= de_pipe[DLY-1] ? q[COLOR_BITS-1:0]              : '0;
            VGA_HS      <= hs_pipe[DLY-1] ? SYNC_ON : ~SYNC_ON;
            VGA_VS      <= vs_pipe[DLY-1] ? SYNC_ON : ~SYNC_ON;
            frame_start <= fs_pipe[DLY-1];
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: scoreboard bench for vga_scanout in a 14x7 small mode.
// Three instances share clock and reset:
//   d0: S=0, RAM_LATENCY=2, active-low sync
//   d1: S=1, RAM_LATENCY=2, active-low sync
//   d2: S=0, RAM_LATENCY=4, active-high sync
// Each has a RAM model returning {a[2:0],a[2:0],a[2:0]} after its latency.
module tb_vga_scanout;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] addr0, addr1, addr2;
    logic [8:0] q0, q1, q2;
    logic [2:0] r0, g0, b0, r1, g1, b1, r2, g2, b2;
    logic       hs0, vs0, fs0, vb0, hs1, vs1, fs1, vb1, hs2, vs2, fs2, vb2;

    always #5 clock = ~clock;

    vga_scanout #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                  .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                  .COLOR_BITS(3), .PIX_SCALE_LOG2(0), .RAM_LATENCY(2),
                  .SYNC_POL(0), .ADDR_WIDTH(5))
    d0 (.clock(clock), .reset(reset), .ram_address(addr0), .q(q0),
        .VGA_R(r0), .VGA_G(g0), .VGA_B(b0), .VGA_HS(hs0), .VGA_VS(vs0),
        .frame_start(fs0), .vblank(vb0));

    vga_scanout #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                  .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                  .COLOR_BITS(3), .PIX_SCALE_LOG2(1), .RAM_LATENCY(2),
                  .SYNC_POL(0), .ADDR_WIDTH(5))
    d1 (.clock(clock), .reset(reset), .ram_address(addr1), .q(q1),
        .VGA_R(r1), .VGA_G(g1), .VGA_B(b1), .VGA_HS(hs1), .VGA_VS(vs1),
        .frame_start(fs1), .vblank(vb1));

    vga_scanout #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                  .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                  .COLOR_BITS(3), .PIX_SCALE_LOG2(0), .RAM_LATENCY(4),
                  .SYNC_POL(1), .ADDR_WIDTH(5))
    d2 (.clock(clock), .reset(reset), .ram_address(addr2), .q(q2),
        .VGA_R(r2), .VGA_G(g2), .VGA_B(b2), .VGA_HS(hs2), .VGA_VS(vs2),
        .frame_start(fs2), .vblank(vb2));

    // RAM models: read data appears RAM_LATENCY clocks after the address.
    logic [4:0] a0p [2];
    logic [4:0] a1p [2];
    logic [4:0] a2p [4];

    always @(posedge clock) begin
        a0p[0] <= addr0;
        a0p[1] <= a0p[0];
        a1p[0] <= addr1;
        a1p[1] <= a1p[0];
        a2p[0] <= addr2;
        for (int i = 1; i < 4; i++) a2p[i] <= a2p[i-1];
    end

    assign q0 = {a0p[1][2:0], a0p[1][2:0], a0p[1][2:0]};
    assign q1 = {a1p[1][2:0], a1p[1][2:0], a1p[1][2:0]};
    assign q2 = {a2p[3][2:0], a2p[3][2:0], a2p[3][2:0]};

    typedef struct {
        int          n;
        logic [17:0] e0;
        logic [17:0] e1;
        logic [17:0] e2;
    } exp_t;

    exp_t sb[$];
    int   n = 0;
    int   checks = 0;
    int   errors = 0;
    int   s1seq[8] = '{0, 0, 1, 1, 2, 2, 3, 3};

    // Address the scan-out should read for raster position p (0..97),
    // in row/column form: row base times W plus column within the row.
    function automatic int posaddr(int p, int s);
        int h, v, mask, w;
        h    = p % 14;
        v    = p / 14;
        mask = (1 << s) - 1;
        w    = 8 >> s;
        if (h < 8 && v < 4) return (v >> s) * w + (h >> s);
        if (v < 4) begin
            if (v == 3) return 0;
            return ((v >> s) + (((v & mask) == mask) ? 1 : 0)) * w;
        end
        return 0;
    endfunction

    // Expected {R,G,B,HS,VS,frame_start,vblank,ram_address} after n
    // unreset clock edges (n = 0 while in reset).
    function automatic logic [17:0] expect_out(int k, int s, int pipe, logic sp);
        logic [17:0] r;
        logic [2:0]  c;
        int          p, h, v;
        r      = '0;
        r[4:0] = (k == 0) ? 5'd0 : 5'(posaddr((k - 1) % 98, s));
        r[5]   = ((k % 98) / 14) >= 4;
        if (k >= pipe) begin
            p = (k - pipe) % 98;
            h = p % 14;
            v = p / 14;
            c = 3'(posaddr(p, s));
            if (h < 8 && v < 4) r[17:9] = {c, c, c};
            r[8] = (h >= 10 && h < 12) ? sp : ~sp;
            r[7] = (v == 5) ? sp : ~sp;
            r[6] = (p == 0);
        end else begin
            r[8] = ~sp;
            r[7] = ~sp;
        end
        return r;
    endfunction

    task automatic applyStimulus(input logic r);
        exp_t e;
        reset = r;
        @(posedge clock);
        #1;
        n    = r ? 0 : n + 1;
        e.n  = n;
        e.e0 = expect_out(n, 0, 4, 1'b0);
        e.e1 = expect_out(n, 1, 4, 1'b0);
        e.e2 = expect_out(n, 0, 6, 1'b1);
        sb.push_back(e);
    endtask

    task automatic checkOutput(input string name, input int k,
                               input logic [17:0] act, input logic [17:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s n=%0d actual=%05h required=%05h", name, k, act, req);
        end
    endtask

    // Monitor: the pins are presented every cycle, so pop one entry per cycle.
    always @(negedge clock) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("d0_s0", e.n, {r0, g0, b0, hs0, vs0, fs0, vb0, addr0}, e.e0);
            checkOutput("d1_s1", e.n, {r1, g1, b1, hs1, vs1, fs1, vb1, addr1}, e.e1);
            checkOutput("d2_pol_lat4", e.n, {r2, g2, b2, hs2, vs2, fs2, vb2, addr2}, e.e2);
            if (e.n >= 1 && e.n <= 8) begin
                checks++;
                if (int'(addr1) != s1seq[e.n-1]) begin
                    errors++;
                    $display("[TB] FAIL s1_line0_addr n=%0d actual=%0d required=%0d",
                             e.n, addr1, s1seq[e.n-1]);
                end
            end
            checks++;
            if (addr1 > 5'd7) begin
                errors++;
                $display("[TB] FAIL s1_max_addr n=%0d actual=%0d required<=7", e.n, addr1);
            end
        end
    end

    initial begin
        reset = 1'b1;
        repeat (3) applyStimulus(1'b1);
        repeat (2 * 98 + 5) applyStimulus(1'b0);
        // Run to h=5, v=2 and hit the design with a short reset there.
        for (int i = 0; i < 98 && (n % 98) != 33; i++) applyStimulus(1'b0);
        repeat (3) applyStimulus(1'b1);
        repeat (98 + 10) applyStimulus(1'b0);
        @(negedge clock);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
Parametrised VGA timing generator and framebuffer scan-out engine. It replaces the fixed-mode VGA block. Timing, colour depth, pixel replication and RAM read latency are all configurable. It drives the read port of the shared dual-port frame RAM and emits RGB/HS/VS aligned to the returned data, plus frame_start and vblank status for the CPU side. It sits in the VGA clock domain between the frame RAM port B and the VGA pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
COLOR_BITS, 3, bits per colour channel
PIX_SCALE_LOG2, 2, each stored pixel is replicated 2^S times horizontally and vertically
RAM_LATENCY, 2, clocks from ram_address registered to q valid
SYNC_POL, 0, asserted level of HS/VS (0 = active-low)
ADDR_WIDTH, 15, frame RAM address width

Ports:
clock  in  1  pixel clock; all logic on its rising edge
reset  in  1  synchronous, active-high
ram_address  out  ADDR_WIDTH  frame RAM read address (port B)
q  in  3*COLOR_BITS  RAM read data, packed {R,G,B}, R in MSBs
VGA_R  out  COLOR_BITS  red
VGA_G  out  COLOR_BITS  green
VGA_B  out  COLOR_BITS  blue
VGA_HS  out  1  horizontal sync
VGA_VS  out  1  vertical sync
frame_start  out  1  one-clock pulse, pin-aligned with first active pixel (0,0)
vblank  out  1  high while v_count >= V_ACTIVE (counter-aligned, not delayed)

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. h_count runs 0..H_TOTAL-1 and wraps. v_count increments on h wrap and wraps at V_TOTAL-1 -> 0.
- Active (de) when h_count < H_ACTIVE and v_count < V_ACTIVE.
- hsync active for H_ACTIVE+H_FP <= h_count < H_ACTIVE+H_FP+H_SYNC. vsync uses the same form on v_count.
- Address generation is incremental with no multiplier; W = H_ACTIVE>>S, where S = PIX_SCALE_LOG2.
  - line_base starts at 0.
  - During active video, the address increments by 1 after every 2^S active pixels, starting at line_base.
  - At the end of an active line: if v_count[S-1:0] is all ones (always true when S=0), line_base += W. Otherwise line_base is unchanged, so the row is repeated.
  - On frame wrap, line_base = 0.
  - During blanking, ram_address = line_base.
- Pipeline: counters at cycle t -> ram_address registered at t+1 -> q valid at t+1+RAM_LATENCY -> pins registered at t+2+RAM_LATENCY. PIPE = RAM_LATENCY+2.
- de, hsync, vsync and frame_start travel through a PIPE-deep delay line so they align with the pixel.
- RGB pins = q fields when delayed de = 1, else 0.
- VGA_HS/VGA_VS = SYNC_POL when delayed sync is active, else ~SYNC_POL.
- Reset:
  - h_count, v_count, line_base and ram_address = 0.
  - RGB = 0, HS/VS = ~SYNC_POL, frame_start = 0, vblank = 0.
  - Delay line is flushed to de = 0, sync inactive.
- Reset asserted mid-frame takes effect on the next edge. After release, counting restarts at (0,0), and frame_start pulses PIPE cycles after the first unreset edge.
- Elaboration-time error if H_ACTIVE or V_ACTIVE is not divisible by 2^S, or if W*(V_ACTIVE>>S) > 2^ADDR_WIDTH.
- The last active address of a frame is W*(V_ACTIVE>>S)-1. The address never exceeds it.

Test Plan:
Use small mode H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2 (H_TOTAL=14), V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=7), RAM_LATENCY=2, S=0, COLOR_BITS=3, ADDR_WIDTH=5, with a RAM model returning q = {addr[2:0], addr[2:0], addr[2:0]}.
- Release reset -> frame_start pulses exactly 4 cycles after release. VGA_R sequence is 0..7 on that line, then 0 during blanking.
- Timing -> VGA_HS low for exactly 2 clocks each line, starting 10 clocks after the line's first pixel. VGA_VS low for exactly 14 clocks per 98-clock frame. vblank high for 3*14 clocks.
- Addressing S=0 -> ram_address visits 0..31 once per frame in order, then returns to 0 at frame wrap.
- S=1 (H_ACTIVE=8, V_ACTIVE=4, W=4) -> each address is held 2 clocks. Line 0 reads 0,0,1,1,2,2,3,3; line 1 repeats this; line 2 reads 4,4,..,7,7. The max address is 7.
- SYNC_POL=1 -> HS/VS idle 0 and pulse 1 with identical timing. RAM_LATENCY=4 -> frame_start and first pixel shift to 6 cycles after reset release.
- Reset asserted at h=5, v=2 for 3 cycles -> outputs are at reset values during reset. ram_address=0 on the first edge after release. The next frame_start comes PIPE cycles after release, with no stray partial-frame pixels after the flush.
